// File: rtl/alu_muldiv_if.sv
// Request/response bundle between the execute-stage control and alu_muldiv.
// The master drives the request; the slave (the ALU) returns results and status.
interface alu_muldiv_if #(
    parameter int N = 32
);
    logic         start;
    logic [3:0]   op;
    logic [N-1:0] inA;
    logic [N-1:0] inB;
    logic [N-1:0] out;
    logic [N-1:0] hi;
    logic         zero;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    modport master (
        output start, op, inA, inB,
        input  out, hi, zero, busy, done, div_by_zero
    );

    modport slave (
        input  start, op, inA, inB,
        output out, hi, zero, busy, done, div_by_zero
    );
endinterface

// File: rtl/alu_muldiv.sv
// Multi-cycle ALU: single-cycle logic/arith/compare ops plus iterative
// one-bit-per-cycle signed/unsigned multiply and restoring divide.
module alu_muldiv #(
    parameter int N = 32
) (
    input  logic         clock,
    input  logic         reset,
    alu_muldiv_if.slave  bus
);
    localparam int CW = $clog2(N + 1);

    localparam logic [3:0] OP_AND   = 4'd0;
    localparam logic [3:0] OP_OR    = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_SLT   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd6;
    localparam logic [3:0] OP_SLTU  = 4'd7;
    localparam logic [3:0] OP_MULTU = 4'd8;
    localparam logic [3:0] OP_MULT  = 4'd9;
    localparam logic [3:0] OP_DIVU  = 4'd10;
    localparam logic [3:0] OP_DIV   = 4'd11;
    localparam logic [3:0] OP_NOR   = 4'd12;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    acc_q, acc_d;    // product high half / partial remainder
    logic [N-1:0]    mq_q, mq_d;      // multiplier / dividend shifting into quotient
    logic [N-1:0]    b_q, b_d;        // multiplicand / divisor magnitude
    logic            is_div_q, is_div_d;
    logic            neg_lo_q, neg_lo_d;
    logic            neg_hi_q, neg_hi_d;
    logic [N-1:0]    out_q, out_d;
    logic [N-1:0]    hi_q, hi_d;
    logic            done_q, done_d;
    logic            dbz_q, dbz_d;

    logic            accept;
    logic            op_iter, op_div, op_sgn;
    logic            a_neg, b_neg;
    logic [N-1:0]    a_mag, b_mag;
    logic [N-1:0]    alu_res;
    logic [N:0]      mul_sum;
    logic [N:0]      div_shl, div_diff;
    logic [2*N-1:0]  prod, prod_fix;

    assign accept  = bus.start && (state_q == IDLE);
    assign op_iter = (bus.op == OP_MULTU) || (bus.op == OP_MULT) ||
                     (bus.op == OP_DIVU)  || (bus.op == OP_DIV);
    assign op_div  = (bus.op == OP_DIVU)  || (bus.op == OP_DIV);
    assign op_sgn  = (bus.op == OP_MULT)  || (bus.op == OP_DIV);
    assign a_neg   = op_sgn && bus.inA[N-1];
    assign b_neg   = op_sgn && bus.inB[N-1];
    assign a_mag   = a_neg ? -bus.inA : bus.inA;
    assign b_mag   = b_neg ? -bus.inB : bus.inB;

    always_comb begin
        alu_res = '0;
        case (bus.op)
            OP_AND:  alu_res = bus.inA & bus.inB;
            OP_OR:   alu_res = bus.inA | bus.inB;
            OP_ADD:  alu_res = bus.inA + bus.inB;
            OP_SUB:  alu_res = bus.inA - bus.inB;
            OP_NOR:  alu_res = ~(bus.inA | bus.inB);
            OP_SLT:  alu_res = {{(N-1){1'b0}}, ($signed(bus.inA) < $signed(bus.inB))};
            OP_SLTU: alu_res = {{(N-1){1'b0}}, (bus.inA < bus.inB)};
            default: alu_res = '0;
        endcase
    end

    // Datapath step values; the partial remainder is always below the divisor,
    // so bit N of the difference is a clean borrow.
    assign mul_sum  = {1'b0, acc_q} + (mq_q[0] ? {1'b0, b_q} : '0);
    assign div_shl  = {acc_q, mq_q[N-1]};
    assign div_diff = div_shl - {1'b0, b_q};
    assign prod     = {acc_q, mq_q};
    assign prod_fix = neg_lo_q ? -prod : prod;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mq_d     = mq_q;
        b_d      = b_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        out_d    = out_q;
        hi_d     = hi_q;
        done_d   = 1'b0;
        dbz_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (op_div && (bus.inB == '0)) begin
                        out_d  = '1;
                        hi_d   = bus.inA;
                        done_d = 1'b1;
                        dbz_d  = 1'b1;
                    end else if (op_iter) begin
                        acc_d    = '0;
                        mq_d     = a_mag;
                        b_d      = b_mag;
                        is_div_d = op_div;
                        neg_lo_d = a_neg ^ b_neg;
                        neg_hi_d = op_div ? a_neg : (a_neg ^ b_neg);
                        cnt_d    = CW'(N);
                        state_d  = RUN;
                    end else begin
                        out_d  = alu_res;
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (is_div_q) begin
                    if (!div_diff[N]) begin
                        acc_d = div_diff[N-1:0];
                        mq_d  = {mq_q[N-2:0], 1'b1};
                    end else begin
                        acc_d = div_shl[N-1:0];
                        mq_d  = {mq_q[N-2:0], 1'b0};
                    end
                end else begin
                    acc_d = mul_sum[N:1];
                    mq_d  = {mul_sum[0], mq_q[N-1:1]};
                end
                if (cnt_q == CW'(1)) state_d = FIX;
            end
            FIX: begin
                if (is_div_q) begin
                    out_d = neg_lo_q ? -mq_q  : mq_q;
                    hi_d  = neg_hi_q ? -acc_q : acc_q;
                end else begin
                    out_d = prod_fix[N-1:0];
                    hi_d  = prod_fix[2*N-1:N];
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mq_q     <= '0;
            b_q      <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            out_q    <= '0;
            hi_q     <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mq_q     <= mq_d;
            b_q      <= b_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            out_q    <= out_d;
            hi_q     <= hi_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign bus.out         = out_q;
    assign bus.hi          = hi_q;
    assign bus.zero        = (out_q == '0);
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_alu_muldiv.sv
// Directed-vector bench for alu_muldiv: results, latency, handshake and abort.
module tb_alu_muldiv;
    localparam int N = 32;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    alu_muldiv_if #(.N(N)) bus();
    alu_muldiv #(.N(N)) dut (.clock(clock), .reset(reset), .bus(bus.slave));

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        @(negedge clock);
        bus.start = 1'b1;
        bus.op    = op;
        bus.inA   = a;
        bus.inB   = b;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        bus.op    = 'x;
        bus.inA   = 'x;
        bus.inB   = 'x;
    endtask

    // cyc = edges after the accepting edge until done is seen; bounded
    task automatic wait_done(output int cyc, output int bcyc);
        cyc  = 0;
        bcyc = 0;
        while (bus.done !== 1'b1 && cyc < 100) begin
            if (bus.busy) bcyc++;
            @(posedge clock);
            #1;
            cyc++;
        end
    endtask

    task automatic run(input string tag, input logic [3:0] op,
                       input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] eo, input logic [N-1:0] eh,
                       input int ecyc, input logic edbz);
        int cyc, bc;
        issue(op, a, b);
        wait_done(cyc, bc);
        chk({tag, ".cyc"},  64'(cyc), 64'(ecyc));
        chk({tag, ".busy"}, 64'(bc),  64'(ecyc));
        chk({tag, ".out"},  64'(bus.out), 64'(eo));
        chk({tag, ".hi"},   64'(bus.hi),  64'(eh));
        chk({tag, ".zero"}, 64'(bus.zero), 64'(eo == '0));
        chk({tag, ".dbz"},  64'(bus.div_by_zero), 64'(edbz));
        @(posedge clock);
        #1;
        chk({tag, ".drop"}, 64'(bus.done), 64'(0));
    endtask

    initial begin
        int cyc, bc;
        logic saw;
        bus.start = 1'b0;
        bus.op    = '0;
        bus.inA   = '0;
        bus.inB   = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst.out",  64'(bus.out), 64'(0));
        chk("rst.hi",   64'(bus.hi), 64'(0));
        chk("rst.busy", 64'(bus.busy), 64'(0));
        chk("rst.done", 64'(bus.done), 64'(0));
        chk("rst.dbz",  64'(bus.div_by_zero), 64'(0));
        chk("rst.zero", 64'(bus.zero), 64'(1));
        @(negedge clock);
        reset = 1'b1;

        run("add",     4'd2,  32'hFFFFFFFF, 32'h2,        32'h1,        32'h0,        0,  1'b0);
        run("sub",     4'd6,  32'h5,        32'h5,        32'h0,        32'h0,        0,  1'b0);
        run("slt",     4'd3,  32'hFFFFFFFF, 32'h1,        32'h1,        32'h0,        0,  1'b0);
        run("sltu",    4'd7,  32'hFFFFFFFF, 32'h1,        32'h0,        32'h0,        0,  1'b0);
        run("and",     4'd0,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'h0,        0,  1'b0);
        run("or",      4'd1,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 32'h0,        0,  1'b0);
        run("nor",     4'd12, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 32'h0,        0,  1'b0);
        run("mult",    4'd9,  32'hFFFFFFFF, 32'h2,        32'hFFFFFFFE, 32'hFFFFFFFF, 33, 1'b0);
        run("multu",   4'd8,  32'hFFFFFFFF, 32'h2,        32'hFFFFFFFE, 32'h1,        33, 1'b0);
        run("undef",   4'd13, 32'h5,        32'h5,        32'h0,        32'h1,        0,  1'b0);
        run("multbig", 4'd9,  32'h7FFFFFFF, 32'h80000000, 32'h80000000, 32'hC0000000, 33, 1'b0);
        run("divu",    4'd10, 32'd100,      32'd7,        32'd14,       32'd2,        33, 1'b0);
        run("divna",   4'd11, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 32'hFFFFFFFF, 33, 1'b0);
        run("divnb",   4'd11, 32'h7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'h1,        33, 1'b0);
        run("divovf",  4'd11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0,        33, 1'b0);
        run("divz",    4'd10, 32'h1234,     32'h0,        32'hFFFFFFFF, 32'h1234,     0,  1'b1);
        run("divzs",   4'd11, 32'hFFFFFFF9, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFF9, 0,  1'b1);

        // start during a multiply must be dropped
        issue(4'd8, 32'd3, 32'd5);
        repeat (9) @(posedge clock);
        @(negedge clock);
        bus.start = 1'b1;
        bus.op    = 4'd2;
        bus.inA   = 32'd7;
        bus.inB   = 32'd8;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        chk("ign.busy", 64'(bus.busy), 64'(1));
        chk("ign.done", 64'(bus.done), 64'(0));
        wait_done(cyc, bc);
        chk("ign.cyc", 64'(cyc), 64'(23));
        chk("ign.out", 64'(bus.out), 64'(15));
        chk("ign.hi",  64'(bus.hi), 64'(0));

        // accept on the done cycle
        bus.start = 1'b1;
        bus.op    = 4'd2;
        bus.inA   = 32'd10;
        bus.inB   = 32'd20;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        chk("b2b.done", 64'(bus.done), 64'(1));
        chk("b2b.out",  64'(bus.out), 64'(30));
        @(posedge clock);
        #1;
        chk("b2b.drop", 64'(bus.done), 64'(0));

        // abort a divide mid-flight
        run("divu2", 4'd10, 32'd100, 32'd7, 32'd14, 32'd2, 33, 1'b0);
        issue(4'd10, 32'hFFFF, 32'd3);
        repeat (19) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("abt.out",  64'(bus.out), 64'(0));
        chk("abt.hi",   64'(bus.hi), 64'(0));
        chk("abt.busy", 64'(bus.busy), 64'(0));
        chk("abt.done", 64'(bus.done), 64'(0));
        chk("abt.zero", 64'(bus.zero), 64'(1));
        chk("abt.dbz",  64'(bus.div_by_zero), 64'(0));
        saw = 1'b0;
        repeat (3) begin
            @(posedge clock);
            #1;
            if (bus.done) saw = 1'b1;
        end
        @(negedge clock);
        reset = 1'b1;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (bus.done || bus.busy) saw = 1'b1;
        end
        chk("abt.quiet", 64'(saw), 64'(0));
        run("post", 4'd2, 32'd1, 32'd2, 32'd3, 32'd0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
